// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen: parametrised LFSR pseudo-random generator (Galois or
// Fibonacci form) with multi-step advance, runtime seeding with zero-seed
// substitution, period measurement and a valid/ready output handshake.
module lfsr_prng_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'h002D),
    parameter int unsigned      MODE  = 0,
    parameter int unsigned      STEPS = 1,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lfsr_enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    output logic [WIDTH-1:0] prn,
    output logic             prn_valid,
    input  logic             prn_ready,
    output logic             seed_err,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] period_len
);

    // Galois form: shift left, fold the tap mask in when the MSB falls out.
    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = {s[WIDTH-2:0], 1'b0};
        if (s[WIDTH-1]) begin
            t = t ^ TAPS;
        end
        return t;
    endfunction

    // Fibonacci form: feedback bit is the MSB XORed with every tapped
    // stage; the x^k term of the mask reads stage k-1.
    function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = s[WIDTH-1];
        for (int k = 1; k < int'(WIDTH); k++) begin
            if (TAPS[k]) begin
                fb = fb ^ s[k-1];
            end
        end
        return {s[WIDTH-2:0], fb};
    endfunction

    logic [WIDTH-1:0] prn_q,        prn_d;
    logic             prn_valid_q,  prn_valid_d;
    logic [WIDTH-1:0] start_q,      start_d;
    logic [WIDTH-1:0] count_q,      count_d;
    logic [WIDTH-1:0] period_q,     period_d;
    logic             seed_err_q,   seed_err_d;
    logic             wrap_q,       wrap_d;

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] seed_eff;
    logic             seed_zero;
    logic             adv;

    // Unrolled next state: STEPS applications of the single-step function.
    always_comb begin
        stepped = prn_q;
        for (int i = 0; i < int'(STEPS); i++) begin
            if (MODE == 0) begin
                stepped = galois_step(stepped);
            end else begin
                stepped = fib_step(stepped);
            end
        end
    end

    // Zero seed would lock the register, so it is replaced by SEED.
    always_comb begin
        seed_zero = (seed_value == '0);
        seed_eff  = seed_zero ? SEED : seed_value;
        // Advance only when the output slot is free or being consumed now,
        // so a stalled value is never overwritten.
        adv       = lfsr_enable && !seed_load && (!prn_valid_q || prn_ready);
    end

    // Next-state logic: seed load beats advance; pulses default low.
    always_comb begin
        prn_d       = prn_q;
        prn_valid_d = prn_valid_q;
        start_d     = start_q;
        count_d     = count_q;
        period_d    = period_q;
        seed_err_d  = 1'b0;
        wrap_d      = 1'b0;
        if (seed_load) begin
            prn_d       = seed_eff;
            start_d     = seed_eff;
            prn_valid_d = 1'b0;
            count_d     = '0;
            seed_err_d  = seed_zero;
        end else if (adv) begin
            prn_d       = stepped;
            prn_valid_d = 1'b1;
            if (stepped == start_q) begin
                // count holds advances since the last start-seed hit minus one.
                wrap_d   = 1'b1;
                period_d = count_q + WIDTH'(1);
                count_d  = '0;
            end else begin
                count_d  = count_q + WIDTH'(1);
            end
        end else if (prn_valid_q && prn_ready) begin
            prn_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prn_q       <= SEED;
            prn_valid_q <= 1'b0;
            start_q     <= SEED;
            count_q     <= '0;
            period_q    <= '0;
            seed_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            prn_q       <= prn_d;
            prn_valid_q <= prn_valid_d;
            start_q     <= start_d;
            count_q     <= count_d;
            period_q    <= period_d;
            seed_err_q  <= seed_err_d;
            wrap_q      <= wrap_d;
        end
    end

    assign prn        = prn_q;
    assign prn_valid  = prn_valid_q;
    assign seed_err   = seed_err_q;
    assign wrap_pulse = wrap_q;
    assign period_len = period_q;

endmodule
